// File: rtl/fanout_valid_broadcast.sv
`default_nettype none
// ============================================================================
// Module      : fanout_valid_broadcast
// Description : Producer side of a routed fanout. One valid/ready upstream
//               token is registered and broadcast to up to NUM_OUT consumers.
//               A consumer participates only when both its config enable and
//               its route-select bit are set. Each participant accepts
//               independently (eager fork). The token retires in the cycle
//               its last pending participant accepts. A new token may load in
//               that same cycle.
// Ports       :
//   clk         in   1        clock, all state on rising edge
//   reset       in   1        synchronous, active-high reset
//   en          in   NUM_OUT  per-destination config enable (static)
//   sel         in   NUM_OUT  per-destination route select (static)
//   in_data     in   DATA_W   upstream token
//   in_valid    in   1        upstream valid
//   in_ready    out  1        upstream ready
//   out_data    out  DATA_W   broadcast token shared by all destinations
//   out_valid   out  NUM_OUT  per-destination valid
//   out_ready   in   NUM_OUT  per-destination ready
//   busy        out  1        holding a token with a pending destination
//   retire_cnt  out  CNT_W    fully retired tokens, wraps modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module fanout_valid_broadcast #(
    parameter int NUM_OUT = 9,
    parameter int DATA_W  = 17,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_OUT-1:0]  en,
    input  logic [NUM_OUT-1:0]  sel,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [NUM_OUT-1:0]  out_valid,
    input  logic [NUM_OUT-1:0]  out_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    retire_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Registered token state
    logic                r_full;
    logic [NUM_OUT-1:0]  r_pend;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_retire_cnt;

    // Combinational control
    logic [NUM_OUT-1:0]  w_active;
    logic [NUM_OUT-1:0]  w_still_pending;
    logic                w_last;
    logic                w_in_ready;
    logic                w_capture;

    // Route mask for a token captured this cycle.
    assign w_active = en & sel;

    // Destinations that remain pending after this cycle's handshakes.
    assign w_still_pending = r_pend & ~out_ready;

    // Every still-pending destination accepts in this cycle.
    assign w_last = r_full & (w_still_pending == '0);

    // Combinational path from out_ready keeps one token per cycle when all
    // participants are ready.
    assign w_in_ready = ~reset & (~r_full | w_last);
    assign w_capture  = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full       <= 1'b0;
            r_pend       <= '0;
            r_data       <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_capture) begin
                // A token with no participants is accepted and dropped:
                // r_full stays low because the route mask is empty.
                r_data <= in_data;
                r_pend <= w_active;
                r_full <= |w_active;
            end else if (w_last) begin
                r_full <= 1'b0;
                r_pend <= '0;
            end else if (r_full) begin
                // Accepted destinations drop out so each sees the token once.
                r_pend <= w_still_pending;
            end

            if (w_last) begin
                r_retire_cnt <= r_retire_cnt + c_cnt_one;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_data;
    assign out_valid  = {NUM_OUT{r_full}} & r_pend;
    assign busy       = r_full;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fanout_valid_broadcast.sv
`default_nettype none
// ============================================================================
// Module      : tb_fanout_valid_broadcast
// Description : Self-checking bench for fanout_valid_broadcast. Directed
//               stimulus, a token scoreboard and a second instance with a
//               4-bit retire counter for the wrap case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fanout_valid_broadcast;

    localparam int NUM_OUT = 9;
    localparam int DATA_W  = 17;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_OUT-1:0] en, sel, out_ready;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;

    logic               in_ready, busy;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [15:0]        retire_cnt;

    logic               in_ready4, busy4;
    logic [DATA_W-1:0]  out_data4;
    logic [NUM_OUT-1:0] out_valid4;
    logic [3:0]         retire_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fanout_valid_broadcast #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .retire_cnt(retire_cnt)
    );

    fanout_valid_broadcast #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .busy(busy4), .retire_cnt(retire_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: tokens pushed with their route mask when the bench sees an
    // accepted upstream handshake; popped when all participants accepted.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [DATA_W-1:0]  d;
        logic [NUM_OUT-1:0] m;
    } tok_t;

    tok_t               sb_q[$];
    logic [NUM_OUT-1:0] delivered = '0;
    int                 exp_cnt   = 0;

    always @(negedge clk) begin
        logic [NUM_OUT-1:0] exp_v;
        logic               exp_ready;
        if (reset) begin
            sb_q.delete();
            delivered = '0;
            exp_cnt   = 0;
            chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        end else begin
            chk("retire_cnt", 32'(retire_cnt), 32'(exp_cnt & 16'hFFFF));
            chk("retire_cnt4", 32'(retire_cnt4), 32'(exp_cnt & 4'hF));
            if (sb_q.size() > 0) begin
                exp_v     = sb_q[0].m & ~delivered;
                exp_ready = ((exp_v & ~out_ready) == '0);
                chk("busy_full", 32'(busy), 32'd1);
                chk("out_data", 32'(out_data), 32'(sb_q[0].d));
                chk("out_valid", 32'(out_valid), 32'(exp_v));
                delivered = delivered | (exp_v & out_ready);
                if (delivered == sb_q[0].m) begin
                    void'(sb_q.pop_front());
                    delivered = '0;
                    exp_cnt++;
                end
            end else begin
                exp_ready = 1'b1;
                chk("busy_empty", 32'(busy), 32'd0);
                chk("out_valid_empty", 32'(out_valid), 32'd0);
            end
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (in_valid && exp_ready && ((en & sel) != '0)) begin
                sb_q.push_back('{d: in_data, m: en & sel});
            end
        end
    end

    // Watchdog: the directed sequence is short.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_OUT-1:0] st_rdy [5];
        logic [NUM_OUT-1:0] st_ov  [5];
        logic               st_ir  [5];
        st_rdy = '{9'h001, 9'h000, 9'h002, 9'h000, 9'h004};
        st_ov  = '{9'h007, 9'h006, 9'h006, 9'h004, 9'h004};
        st_ir  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held two cycles with in_valid high
        reset = 1'b1; in_valid = 1'b1; in_data = 17'h00123;
        en = 9'h1FF; sel = 9'h1FF; out_ready = '0;
        tick; tick;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Broadcast to destinations 0 and 2
        sel = 9'h005; out_ready = 9'h1FF; in_data = 17'h00ABC; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("bc_out_valid", 32'(out_valid), 32'h005);
        chk("bc_out_data", 32'(out_data), 32'h0ABC);
        tick;
        chk("bc_out_valid_after", 32'(out_valid), 32'h000);
        chk("bc_retire_cnt", 32'(retire_cnt), 32'd1);

        // Staggered accept
        sel = 9'h007; out_ready = '0; in_data = 17'h01111; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_ready = st_rdy[i];
            #1;
            chk($sformatf("stag_ov%0d", i), 32'(out_valid), 32'(st_ov[i]));
            chk($sformatf("stag_ir%0d", i), 32'(in_ready), 32'(st_ir[i]));
            tick;
        end
        chk("stag_ov_end", 32'(out_valid), 32'h000);
        chk("stag_retire_cnt", 32'(retire_cnt), 32'd2);

        // Throughput: 8 back-to-back tokens
        sel = 9'h1FF; out_ready = 9'h1FF; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 17'(17'h10000 + i * 17'h111);
            #1;
            chk($sformatf("tp_in_ready%0d", i), 32'(in_ready), 32'd1);
            tick;
            chk($sformatf("tp_out_valid%0d", i), 32'(out_valid), 32'h1FF);
        end
        in_valid = 1'b0;
        tick;
        chk("tp_retire_cnt", 32'(retire_cnt), 32'd10);

        // Disabled / empty route: tokens dropped
        en = 9'h0F0; sel = 9'h00F; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 17'(17'h00200 + i);
            #1;
            chk($sformatf("drop_in_ready%0d", i), 32'(in_ready), 32'd1);
            tick;
            chk($sformatf("drop_out_valid%0d", i), 32'(out_valid), 32'h000);
        end
        in_valid = 1'b0;
        tick;
        chk("drop_retire_cnt", 32'(retire_cnt), 32'd10);

        // Config change while a token is in flight
        en = 9'h1FF; sel = 9'h003; out_ready = '0; in_data = 17'h0AAAA; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; sel = 9'h100;
        #1;
        chk("cfg_ov_hold0", 32'(out_valid), 32'h003);
        tick;
        chk("cfg_ov_hold1", 32'(out_valid), 32'h003);
        out_ready = 9'h1FF; in_data = 17'h05555; in_valid = 1'b1;
        #1;
        chk("cfg_in_ready_last", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("cfg_next_ov", 32'(out_valid), 32'h100);
        chk("cfg_next_data", 32'(out_data), 32'h05555);
        tick;
        chk("cfg_retire_cnt", 32'(retire_cnt), 32'd12);

        // Reset asserted mid-token
        sel = 9'h1FF; out_ready = '0; in_data = 17'h0BEEF; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'h000);
        chk("mid_rst_cnt", 32'(retire_cnt), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        // Counter wrap on the 4-bit instance: 17 retirements
        sel = 9'h001; out_ready = 9'h1FF; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 17'(i);
            tick;
        end
        in_valid = 1'b0;
        tick;
        chk("wrap_cnt16", 32'(retire_cnt), 32'd17);
        chk("wrap_cnt4", 32'(retire_cnt4), 32'd1);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
